// File: rtl/mysoc_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mysoc_bus_pkg
// Purpose  : Shared types and defaults for the CPU-to-SoC memory bus arbiter.
// Revision : 1.0  initial release
// ============================================================================
package mysoc_bus_pkg;

    localparam int c_DEFAULT_AW = 32;
    localparam int c_DEFAULT_DW = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } arbState_t;

    typedef enum logic {
        GNT_INST = 1'b0,
        GNT_DATA = 1'b1
    } grant_t;

endpackage
`default_nettype wire

// File: rtl/cpu_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : cpu_mem_arbiter_if
// Purpose  : Fetch port, data port and shared bus signals of the memory arbiter.
// Revision : 1.0  initial release
// ============================================================================
interface cpu_mem_arbiter_if
    import mysoc_bus_pkg::*;
#(
    parameter int AW = c_DEFAULT_AW,
    parameter int DW = c_DEFAULT_DW
) ();

    logic              inst_req;
    logic [AW-1:0]     inst_addr;
    logic [DW-1:0]     inst_rdata;
    logic              inst_data_ok;

    logic              data_req;
    logic              data_wr;
    logic [DW/8-1:0]   data_wstrb;
    logic [AW-1:0]     data_addr;
    logic [DW-1:0]     data_wdata;
    logic [DW-1:0]     data_rdata;
    logic              data_data_ok;

    logic              bus_req;
    logic              bus_wr;
    logic [DW/8-1:0]   bus_wstrb;
    logic [AW-1:0]     bus_addr;
    logic [DW-1:0]     bus_wdata;
    logic              bus_addr_ok;
    logic              bus_data_ok;
    logic [DW-1:0]     bus_rdata;

    logic              stall;

    // Arbiter side
    modport slave (
        input  inst_req, inst_addr,
        input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
        input  bus_addr_ok, bus_data_ok, bus_rdata,
        output inst_rdata, inst_data_ok, data_rdata, data_data_ok,
        output bus_req, bus_wr, bus_wstrb, bus_addr, bus_wdata,
        output stall
    );

    // Core and memory side
    modport master (
        output inst_req, inst_addr,
        output data_req, data_wr, data_wstrb, data_addr, data_wdata,
        output bus_addr_ok, bus_data_ok, bus_rdata,
        input  inst_rdata, inst_data_ok, data_rdata, data_data_ok,
        input  bus_req, bus_wr, bus_wstrb, bus_addr, bus_wdata,
        input  stall
    );

endinterface
`default_nettype wire

// File: rtl/arb_rr2.sv
`default_nettype none
// ============================================================================
// Module   : arb_rr2
// Purpose  : Two-input round-robin grant with a one-bit last-grant history.
// Revision : 1.0  initial release
// ============================================================================
module arb_rr2
    import mysoc_bus_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   i_instReq,
    input  logic   i_dataReq,
    input  logic   i_advance,
    output grant_t o_grant
);

    grant_t r_lastGrant;

    // On a tie the port served most recently loses.
    always_comb begin
        o_grant = GNT_INST;
        if (i_instReq && i_dataReq) begin
            if (r_lastGrant == GNT_INST) begin
                o_grant = GNT_DATA;
            end else begin
                o_grant = GNT_INST;
            end
        end else if (i_dataReq) begin
            o_grant = GNT_DATA;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lastGrant <= GNT_INST;
        end else if (i_advance) begin
            r_lastGrant <= o_grant;
        end
    end

endmodule
`default_nettype wire

// File: rtl/cpu_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cpu_mem_arbiter
// Purpose  : Serialises MIPS fetch and data accesses onto one shared bus.
// Revision : 1.0  initial release
// ============================================================================
module cpu_mem_arbiter
    import mysoc_bus_pkg::*;
#(
    parameter int AW = c_DEFAULT_AW,
    parameter int DW = c_DEFAULT_DW
) (
    input  logic                 clk,
    input  logic                 rst,
    cpu_mem_arbiter_if.slave     arbIf
);

    arbState_t         r_state;
    grant_t            r_grant;
    logic              r_busReq;
    logic              r_busWr;
    logic [DW/8-1:0]   r_busWstrb;
    logic [AW-1:0]     r_busAddr;
    logic [DW-1:0]     r_busWdata;
    logic [DW-1:0]     r_instRdata;
    logic [DW-1:0]     r_dataRdata;
    logic              r_instOk;
    logic              r_dataOk;

    logic              w_anyReq;
    logic              w_advance;
    logic              w_complete;
    grant_t            w_grant;

    assign w_anyReq   = arbIf.inst_req | arbIf.data_req;
    assign w_advance  = (r_state == IDLE) && w_anyReq;
    assign w_complete = ((r_state == ADDR) && arbIf.bus_addr_ok && arbIf.bus_data_ok) ||
                        ((r_state == DATA) && arbIf.bus_data_ok);

    arb_rr2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .i_instReq (arbIf.inst_req),
        .i_dataReq (arbIf.data_req),
        .i_advance (w_advance),
        .o_grant   (w_grant)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_grant     <= GNT_INST;
            r_busReq    <= 1'b0;
            r_busWr     <= 1'b0;
            r_busWstrb  <= '0;
            r_busAddr   <= '0;
            r_busWdata  <= '0;
            r_instRdata <= '0;
            r_dataRdata <= '0;
            r_instOk    <= 1'b0;
            r_dataOk    <= 1'b0;
        end else begin
            r_instOk <= 1'b0;
            r_dataOk <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (w_anyReq) begin
                        r_grant  <= w_grant;
                        r_busReq <= 1'b1;
                        r_state  <= ADDR;
                        if (w_grant == GNT_DATA) begin
                            r_busAddr  <= arbIf.data_addr;
                            r_busWr    <= arbIf.data_wr;
                            r_busWstrb <= arbIf.data_wstrb;
                            r_busWdata <= arbIf.data_wdata;
                        end else begin
                            r_busAddr  <= arbIf.inst_addr;
                            r_busWr    <= 1'b0;
                            r_busWstrb <= '0;
                            r_busWdata <= '0;
                        end
                    end
                end
                ADDR: begin
                    if (arbIf.bus_addr_ok) begin
                        r_busReq <= 1'b0;
                        if (arbIf.bus_data_ok) begin
                            r_state <= RESP;
                        end else begin
                            r_state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (arbIf.bus_data_ok) begin
                        r_state <= RESP;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase

            // Completion raises the owner's pulse in RESP; stores leave read data alone.
            if (w_complete) begin
                if (r_grant == GNT_DATA) begin
                    r_dataOk <= 1'b1;
                    if (!r_busWr) begin
                        r_dataRdata <= arbIf.bus_rdata;
                    end
                end else begin
                    r_instOk <= 1'b1;
                    if (!r_busWr) begin
                        r_instRdata <= arbIf.bus_rdata;
                    end
                end
            end
        end
    end

    assign arbIf.bus_req      = r_busReq;
    assign arbIf.bus_wr       = r_busWr;
    assign arbIf.bus_wstrb    = r_busWstrb;
    assign arbIf.bus_addr     = r_busAddr;
    assign arbIf.bus_wdata    = r_busWdata;
    assign arbIf.inst_rdata   = r_instRdata;
    assign arbIf.data_rdata   = r_dataRdata;
    assign arbIf.inst_data_ok = r_instOk;
    assign arbIf.data_data_ok = r_dataOk;

    assign arbIf.stall = ~rst & ((arbIf.inst_req & ~r_instOk) | (arbIf.data_req & ~r_dataOk));

endmodule
`default_nettype wire

// File: tb/tb_cpu_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_mem_arbiter
// Purpose  : Directed self-checking bench for cpu_mem_arbiter.
// Revision : 1.0  initial release
// ============================================================================
module tb_cpu_mem_arbiter;
    import mysoc_bus_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cpu_mem_arbiter_if #(.AW(AW), .DW(DW)) arbIf ();

    cpu_mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk   (clk),
        .rst   (rst),
        .arbIf (arbIf)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        logic        isData;
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          aDly;
        int          dDly;
        int          expReqCycles;
        int          expLatency;
        logic [31:0] expInst;
        logic [31:0] expData;
    } vec_t;

    vec_t   vecs[6];
    grant_t expOrd[6];

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [159:0] outs();
        return {arbIf.bus_req, arbIf.bus_wr, arbIf.bus_wstrb, arbIf.bus_addr, arbIf.bus_wdata,
                arbIf.inst_rdata, arbIf.data_rdata, arbIf.inst_data_ok, arbIf.data_data_ok};
    endfunction

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic idleInputs();
        arbIf.inst_req    = 1'b0;
        arbIf.inst_addr   = '0;
        arbIf.data_req    = 1'b0;
        arbIf.data_wr     = 1'b0;
        arbIf.data_wstrb  = '0;
        arbIf.data_addr   = '0;
        arbIf.data_wdata  = '0;
        arbIf.bus_addr_ok = 1'b0;
        arbIf.bus_data_ok = 1'b0;
        arbIf.bus_rdata   = 32'hFFFF_FFFF;
    endtask

    task automatic applyReset(input string tag);
        idleInputs();
        arbIf.inst_req = 1'b1;
        arbIf.data_req = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        check({tag, "_stall_in_rst"}, 160'(arbIf.stall), 160'(0));
        check({tag, "_reset_outputs"}, outs(), '0);
        arbIf.inst_req = 1'b0;
        arbIf.data_req = 1'b0;
        rst = 1'b0;
        tick();
        check({tag, "_idle_after_rst"}, outs(), '0);
    endtask

    // One isolated transaction with a delayed-handshake bus model.
    task automatic runTxn(input vec_t v, input int idx);
        int   reqCycles = 0;
        int   lat = 0;
        int   aCnt = 0;
        int   dCnt = 0;
        int   otherOk = 0;
        bit   accepted = 0;
        bit   dataGiven = 0;
        bit   done = 0;
        logic myOk;
        string tg = $sformatf("v%0d", idx);

        if (v.isData) begin
            arbIf.data_req   = 1'b1;
            arbIf.data_wr    = v.wr;
            arbIf.data_addr  = v.addr;
            arbIf.data_wstrb = v.wstrb;
            arbIf.data_wdata = v.wdata;
        end else begin
            arbIf.inst_req  = 1'b1;
            arbIf.inst_addr = v.addr;
        end

        for (int c = 0; c < 40 && !done; c++) begin
            tick();
            lat++;
            myOk = v.isData ? arbIf.data_data_ok : arbIf.inst_data_ok;
            if ((v.isData ? arbIf.inst_data_ok : arbIf.data_data_ok) == 1'b1) otherOk++;
            arbIf.bus_addr_ok = 1'b0;
            arbIf.bus_data_ok = 1'b0;
            arbIf.bus_rdata   = 32'hFFFF_FFFF;

            if (myOk) begin
                check({tg, "_stall_at_ok"}, 160'(arbIf.stall), 160'(0));
                check({tg, "_latency"}, 160'(lat), 160'(v.expLatency));
                done = 1;
                arbIf.inst_req = 1'b0;
                arbIf.data_req = 1'b0;
            end else begin
                check({tg, "_stall_wait"}, 160'(arbIf.stall), 160'(1));
            end

            if (arbIf.bus_req) begin
                reqCycles++;
                check({tg, "_bus_addr_wr"}, {arbIf.bus_addr, arbIf.bus_wr}, {v.addr, v.wr});
                if (v.wr) check({tg, "_bus_wstrb_wdata"}, {arbIf.bus_wstrb, arbIf.bus_wdata}, {v.wstrb, v.wdata});
                if (v.isData) begin
                    arbIf.data_addr  = ~v.addr;
                    arbIf.data_wr    = ~v.wr;
                    arbIf.data_wstrb = ~v.wstrb;
                    arbIf.data_wdata = ~v.wdata;
                end
                if (aCnt == v.aDly) begin
                    arbIf.bus_addr_ok = 1'b1;
                    accepted = 1;
                    if (v.dDly == 0) begin
                        arbIf.bus_data_ok = 1'b1;
                        arbIf.bus_rdata   = v.rdata;
                        dataGiven = 1;
                    end
                end else begin
                    aCnt++;
                end
            end else if (accepted && !dataGiven) begin
                dCnt++;
                if (dCnt == v.dDly) begin
                    arbIf.bus_data_ok = 1'b1;
                    arbIf.bus_rdata   = v.rdata;
                    dataGiven = 1;
                end
            end
        end

        check({tg, "_completed"}, 160'(done), 160'(1));
        check({tg, "_bus_req_cycles"}, 160'(reqCycles), 160'(v.expReqCycles));
        idleInputs();
        tick();
        check({tg, "_single_pulse"}, {arbIf.inst_data_ok, arbIf.data_data_ok, arbIf.bus_req}, 160'(0));
        check({tg, "_other_port_quiet"}, 160'(otherOk), 160'(0));
        check({tg, "_rdata"}, {arbIf.inst_rdata, arbIf.data_rdata}, {v.expInst, v.expData});
    endtask

    // Both ports request continuously; bus answers immediately.
    task automatic runDual();
        int   k = 0;
        int   instLeft = 3;
        int   dataLeft = 3;
        int   respCyc  = -1;
        bit   reInst = 0;
        bit   reData = 0;
        bit   instOk;
        bit   dataOk;
        grant_t got;

        idleInputs();
        arbIf.inst_addr = 32'h0000_2000;
        arbIf.data_addr = 32'h0000_0400;
        arbIf.inst_req  = 1'b1;
        arbIf.data_req  = 1'b1;

        for (int c = 0; c < 200 && k < 6; c++) begin
            tick();
            instOk = arbIf.inst_data_ok;
            dataOk = arbIf.data_data_ok;
            if (reInst && instLeft > 0) arbIf.inst_req = 1'b1;
            if (reData && dataLeft > 0) arbIf.data_req = 1'b1;
            reInst = 0;
            reData = 0;
            arbIf.bus_addr_ok = 1'b0;
            arbIf.bus_data_ok = 1'b0;
            arbIf.bus_rdata   = 32'hFFFF_FFFF;

            if (instOk || dataOk) begin
                got = dataOk ? GNT_DATA : GNT_INST;
                check($sformatf("dual%0d_order", k), 160'(got), 160'(expOrd[k]));
                check($sformatf("dual%0d_both_ok", k), 160'(instOk & dataOk), 160'(0));
                check($sformatf("dual%0d_rdata", k), dataOk ? arbIf.data_rdata : arbIf.inst_rdata,
                      160'(32'hA000_0000 + k));
                check($sformatf("dual%0d_stall", k), 160'(arbIf.stall), (k == 5) ? 160'(0) : 160'(1));
                if (k == 0) respCyc = cyc;
                if (dataOk) begin
                    arbIf.data_req = 1'b0; dataLeft--; reData = 1;
                end else begin
                    arbIf.inst_req = 1'b0; instLeft--; reInst = 1;
                end
                k++;
            end else begin
                check($sformatf("dual%0d_stall_wait", k), 160'(arbIf.stall), 160'(1));
            end

            if (arbIf.bus_req && k < 6) begin
                check($sformatf("dual%0d_bus_addr", k), 160'(arbIf.bus_addr),
                      (expOrd[k] == GNT_DATA) ? 160'(32'h0000_0400) : 160'(32'h0000_2000));
                if (k == 1) check("dual_inst_start_after_resp_idle", 160'(cyc), 160'(respCyc + 2));
                arbIf.bus_addr_ok = 1'b1;
                arbIf.bus_data_ok = 1'b1;
                arbIf.bus_rdata   = 32'hA000_0000 + k;
            end
        end
        check("dual_all_done", 160'(k), 160'(6));
        idleInputs();
        tick();
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b0, 32'h0000_0100, 4'b0000, 32'h0,          32'hDEAD_BEEF, 0, 0, 1, 2, 32'h0,          32'hDEAD_BEEF};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_0200, 4'b0011, 32'h1234_5678, 32'hBAD0_BAD0, 3, 2, 4, 7, 32'h0,          32'hDEAD_BEEF};
        vecs[2] = '{1'b0, 1'b0, 32'h0000_1000, 4'b0000, 32'h0,          32'h2402_0005, 1, 0, 2, 3, 32'h2402_0005, 32'hDEAD_BEEF};
        vecs[3] = '{1'b1, 1'b0, 32'h0000_0104, 4'b0000, 32'h0,          32'hCAFE_F00D, 0, 3, 1, 5, 32'h2402_0005, 32'hCAFE_F00D};
        vecs[4] = '{1'b0, 1'b0, 32'h0000_1004, 4'b0000, 32'h0,          32'h8C43_0010, 2, 1, 3, 5, 32'h8C43_0010, 32'hCAFE_F00D};
        vecs[5] = '{1'b1, 1'b1, 32'h0000_0300, 4'b1100, 32'hAABB_CCDD, 32'h1111_1111, 0, 0, 1, 2, 32'h8C43_0010, 32'hCAFE_F00D};
        expOrd  = '{GNT_DATA, GNT_INST, GNT_DATA, GNT_INST, GNT_DATA, GNT_INST};

        applyReset("rst0");
        runDual();

        applyReset("rst1");
        for (int i = 0; i < 6; i++) begin
            runTxn(vecs[i], i);
        end

        // Abort a load while waiting for data, then deliver a stale data_ok.
        arbIf.data_req  = 1'b1;
        arbIf.data_wr   = 1'b0;
        arbIf.data_addr = 32'h0000_0500;
        tick();
        check("abort_addr_phase", 160'(arbIf.bus_req), 160'(1));
        arbIf.bus_addr_ok = 1'b1;
        tick();
        check("abort_data_phase", {arbIf.bus_req, arbIf.data_data_ok}, 160'(0));
        arbIf.bus_addr_ok = 1'b0;
        arbIf.data_req    = 1'b0;
        rst = 1'b1;
        tick();
        check("abort_reset_outputs", outs(), '0);
        check("abort_stall_in_rst", 160'(arbIf.stall), 160'(0));
        rst = 1'b0;
        arbIf.bus_data_ok = 1'b1;
        arbIf.bus_rdata   = 32'h55AA_55AA;
        tick();
        check("abort_late_data_ok", outs(), '0);
        arbIf.bus_data_ok = 1'b0;
        tick();
        tick();
        check("abort_quiet", {outs(), arbIf.stall}, '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
